// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        RUN,
        ERROR
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic int timeout_cnt_w(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs little-endian bytes into 32-bit words; flags the byte that completes a word.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] shift;

    // The 4th byte is combined combinationally so the write can be registered one cycle later.
    assign word_valid = byte_valid && !clear && (byte_idx == 2'd3);
    assign word       = {byte_data, shift};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            shift    <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            shift    <= '0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            shift    <= {byte_data, shift[23:8]};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed, checksummed byte stream into IMEM and holds the core in reset until it is valid.
module imem_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error
);

    localparam int              TO_W      = timeout_cnt_w(TIMEOUT_CYC);
    localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    state_t            state, state_next;
    logic [7:0]        len_lo;
    logic [15:0]       n_words;
    logic [ADDR_W:0]   addr_cnt;
    logic [7:0]        chk;
    logic [TO_W-1:0]   idle_cnt;
    logic [16:0]       len_full;
    logic              timed, timeout_hit, data_byte, word_valid, word_fire, last_word;
    logic [31:0]       word;

    assign len_full    = {1'b0, rx_data, len_lo};
    assign timed       = state inside {LEN_LO, LEN_HI, DATA, CHECK};
    assign timeout_hit = timed && !rx_valid && (idle_cnt == TO_LAST);
    assign data_byte   = (state == DATA) && rx_valid;
    assign word_fire   = data_byte && word_valid;
    assign last_word   = (32'(addr_cnt) + 32'd1) == 32'(n_words);

    // Leaving DATA for any reason discards a partially assembled word.
    word_assembler u_word_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state != DATA),
        .byte_valid (data_byte),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (rx_valid && rx_data == SYNC_BYTE) state_next = LEN_LO;
            LEN_LO: if (rx_valid) state_next = LEN_HI;
            LEN_HI: begin
                if (rx_valid) begin
                    if (len_full > MAX_WORDS)   state_next = ERROR;
                    else if (len_full == 17'd0) state_next = CHECK;
                    else                        state_next = DATA;
                end
            end
            DATA:   if (word_fire && last_word) state_next = CHECK;
            CHECK:  if (rx_valid) state_next = (rx_data == chk) ? RUN : ERROR;
            RUN:    if (reload) state_next = IDLE;
            ERROR:  if (rx_valid && rx_data == SYNC_BYTE) state_next = LEN_LO;
            default: state_next = IDLE;
        endcase
        if (timeout_hit) state_next = ERROR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_lo     <= '0;
            n_words    <= '0;
            addr_cnt   <= '0;
            chk        <= '0;
            idle_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state    <= state_next;
            idle_cnt <= (timed && !rx_valid) ? idle_cnt + 1'b1 : '0;

            if (state == LEN_LO && rx_valid) len_lo <= rx_data;

            if (state == LEN_HI && rx_valid) begin
                n_words  <= {rx_data, len_lo};
                addr_cnt <= '0;
                chk      <= '0;
            end else begin
                if (word_fire) addr_cnt <= addr_cnt + 1'b1;
                if (data_byte) chk <= chk ^ rx_data;
            end

            imem_we <= word_fire;
            if (word_fire) begin
                imem_addr  <= addr_cnt[ADDR_W-1:0];
                imem_wdata <= word;
            end

            // Status flags follow the state being entered, so they change one cycle after the event.
            core_rst_n <= (state_next == RUN);
            done       <= (state_next == RUN);
            error      <= (state_next == ERROR);
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed plus randomized frame bench with a frame-level reference model of the boot loader.
module tb_imem_boot_loader;

    localparam int         ADDR_W      = 4;
    localparam int         TIMEOUT_CYC = 10;
    localparam logic [7:0] SYNC        = 8'hA5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    imem_boot_loader #(
        .ADDR_W      (ADDR_W),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    int tests  = 0;
    int failed = 0;
    logic [ADDR_W+31:0] wr_q[$];
    logic [7:0]         frame_q[$];

    // Every cycle with imem_we high is one observed write.
    always @(negedge clk) begin
        if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i]);
            if (i != frame_q.size() - 1 && maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
        end
    endtask

    task automatic pulse_reload(input logic with_byte);
        reload   = 1'b1;
        rx_valid = with_byte;
        rx_data  = SYNC;
        @(negedge clk);
        reload   = 1'b0;
        rx_valid = 1'b0;
    endtask

    // Reference: words are consecutive little-endian groups of 4 data bytes,
    // the frame succeeds only if its length fits and the last byte is the XOR of the data.
    task automatic check_frame(input string tag, output bit run_exp);
        int n, nexp;
        logic [7:0]  x;
        logic [31:0] w;
        n       = int'(frame_q[1]) | (int'(frame_q[2]) << 8);
        run_exp = 1'b0;
        nexp    = 0;
        if (n <= (1 << ADDR_W)) begin
            nexp = n;
            x    = 8'h00;
            for (int i = 0; i < 4 * n; i++) x ^= frame_q[3 + i];
            run_exp = (frame_q[3 + 4 * n] == x);
        end
        chk({tag, ".nwr"}, 64'(wr_q.size()), 64'(nexp));
        for (int k = 0; k < nexp && k < wr_q.size(); k++) begin
            w = {frame_q[3 + 4*k + 3], frame_q[3 + 4*k + 2], frame_q[3 + 4*k + 1], frame_q[3 + 4*k]};
            chk($sformatf("%s.wr%0d", tag, k), 64'(wr_q[k]), 64'({ADDR_W'(k), w}));
        end
        chk({tag, ".done"},       64'(done),       64'(run_exp));
        chk({tag, ".error"},      64'(error),      64'(!run_exp));
        chk({tag, ".core_rst_n"}, 64'(core_rst_n), 64'(run_exp));
    endtask

    initial begin
        bit          run_exp;
        int          n;
        logic [7:0]  x, b;

        rst_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.imem_we",    64'(imem_we),    64'd0);
        chk("rst.imem_addr",  64'(imem_addr),  64'd0);
        chk("rst.imem_wdata", 64'(imem_wdata), 64'd0);
        chk("rst.core_rst_n", 64'(core_rst_n), 64'd0);
        chk("rst.done",       64'(done),       64'd0);
        chk("rst.error",      64'(error),      64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Good frame with explicit write-latency check.
        wr_q.delete();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        for (int i = 0; i < 7; i++) send_byte(frame_q[i]);
        chk("good.we_w0",    64'(imem_we),    64'd1);
        chk("good.addr_w0",  64'(imem_addr),  64'd0);
        chk("good.wdata_w0", 64'(imem_wdata), 64'h44332211);
        send_byte(frame_q[7]);
        chk("good.we_pulse", 64'(imem_we),    64'd0);
        for (int i = 8; i < 11; i++) send_byte(frame_q[i]);
        chk("good.held_before_chk", 64'(core_rst_n), 64'd0);
        send_byte(frame_q[11]);
        check_frame("good", run_exp);

        // Reload together with a sync byte: reload wins, then noise is ignored.
        pulse_reload(1'b1);
        chk("reload.core_rst_n", 64'(core_rst_n), 64'd0);
        chk("reload.done",       64'(done),       64'd0);
        send_byte(8'h00);
        send_byte(8'hFF);
        idle(2);
        chk("noise.error", 64'(error), 64'd0);
        chk("noise.done",  64'(done),  64'd0);

        // Zero-length frame.
        wr_q.delete();
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        check_frame("zero", run_exp);
        pulse_reload(1'b0);

        // Bad checksum, then a good frame straight out of ERROR.
        wr_q.delete();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        send_frame(0);
        check_frame("badchk", run_exp);
        wr_q.delete();
        frame_q[11] = 8'h88;
        send_frame(2);
        check_frame("recover", run_exp);
        pulse_reload(1'b0);

        // Oversize length, then the largest legal length.
        wr_q.delete();
        frame_q = '{8'hA5, 8'h11, 8'h00};
        send_frame(0);
        idle(1);
        check_frame("oversize", run_exp);
        wr_q.delete();
        frame_q = '{8'hA5, 8'h10, 8'h00};
        x = 8'h00;
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom);
            x ^= b;
            frame_q.push_back(b);
        end
        frame_q.push_back(x);
        send_frame(0);
        check_frame("full", run_exp);
        pulse_reload(1'b0);

        // Inter-byte timeout inside a word.
        wr_q.delete();
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
        send_frame(0);
        idle(TIMEOUT_CYC - 1);
        chk("timeout.before", 64'(error), 64'd0);
        idle(1);
        chk("timeout.error",      64'(error),       64'd1);
        chk("timeout.core_rst_n", 64'(core_rst_n),  64'd0);
        chk("timeout.nwr",        64'(wr_q.size()), 64'd0);

        // Asynchronous reset in the middle of DATA.
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h34};
        send_frame(0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.imem_we",    64'(imem_we),    64'd0);
        chk("arst.imem_addr",  64'(imem_addr),  64'd0);
        chk("arst.imem_wdata", 64'(imem_wdata), 64'd0);
        chk("arst.core_rst_n", 64'(core_rst_n), 64'd0);
        chk("arst.done",       64'(done),       64'd0);
        chk("arst.error",      64'(error),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        wr_q.delete();
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF};
        send_frame(0);
        check_frame("post_arst", run_exp);

        // Randomized frames with random gaps and occasional corrupted checksums.
        for (int f = 0; f < 8; f++) begin
            if (run_exp) pulse_reload(1'b0);
            wr_q.delete();
            n = int'($urandom_range(16, 1));
            frame_q = '{SYNC, 8'(n), 8'h00};
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x ^= b;
                frame_q.push_back(b);
            end
            if ($urandom_range(1, 0) == 1) x ^= 8'($urandom_range(255, 1));
            frame_q.push_back(x);
            send_frame(3);
            check_frame($sformatf("rand%0d", f), run_exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
